// File: rtl/float_pkg.sv
// Shared floating-point definitions for the divider and its result queue.
package float_pkg;

   // Bit positions of the exception flags inside a 3-bit flag vector.
   localparam int unsigned FLAG_OVERFLOW  = 2;
   localparam int unsigned FLAG_UNDERFLOW = 1;
   localparam int unsigned FLAG_INEXACT   = 0;

   // Single-precision defaults, shared with the divider.
   localparam int unsigned FLOAT_SIZE_SP = 32;
   localparam int unsigned EXP_SIZE      = 8;
   localparam int unsigned MANT_SIZE     = 23;
   localparam int unsigned EXP_BIAS      = 127;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
   } float_flags_t;

   // True when the exponent field is all ones (infinity or NaN).
   function automatic logic is_special(input logic [FLOAT_SIZE_SP-1:0] f);
      return &f[MANT_SIZE +: EXP_SIZE];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and an occupancy counter.
module sync_fifo
   import float_pkg::*;
#(
   parameter int unsigned WIDTH = 35,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset clears storage so the head reads as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/float_div_result_queue.sv
// Result queue behind the FP divider with sticky exception status.
module float_div_result_queue
   import float_pkg::*;
#(
   parameter int unsigned FLOAT_SIZE = FLOAT_SIZE_SP,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [FLOAT_SIZE-1:0]    in_float,
   input  logic                     in_overflow,
   input  logic                     in_underflow,
   input  logic                     in_inexact,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [FLOAT_SIZE-1:0]    out_float,
   output logic [2:0]               out_flags,
   output logic [$clog2(DEPTH):0]   count,
   output logic [2:0]               sticky_flags,
   output logic [7:0]               exc_count,
   input  logic                     clear_status
);

   localparam int unsigned WIDTH = FLOAT_SIZE + 3;
   localparam logic [7:0]  EXC_MAX = 8'hFF;

   logic             full, empty, push, pop;
   logic [2:0]       in_flags;
   logic [WIDTH-1:0] rdata;

   float_flags_t     sticky_q, sticky_d;
   logic [7:0]       exc_q, exc_d;

   // Pack the incoming flags into their fixed bit positions.
   always_comb begin
      in_flags                 = '0;
      in_flags[FLAG_OVERFLOW]  = in_overflow;
      in_flags[FLAG_UNDERFLOW] = in_underflow;
      in_flags[FLAG_INEXACT]   = in_inexact;
   end

   assign push = in_valid & ~full;
   assign pop  = ~empty & out_ready;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata ({in_float, in_flags}),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Sticky/exception-count update: clear forms the base, a push then adds on top.
   always_comb begin
      sticky_d = clear_status ? '0 : sticky_q;
      exc_d    = clear_status ? '0 : exc_q;
      if (push) begin
         sticky_d = sticky_d | float_flags_t'(in_flags);
         if ((in_flags != '0) && (exc_d != EXC_MAX)) begin
            exc_d = exc_d + 1'b1;
         end
      end
   end

   // Status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= '0;
         exc_q    <= '0;
      end else begin
         sticky_q <= sticky_d;
         exc_q    <= exc_d;
      end
   end

   assign in_ready     = ~full;
   assign out_valid    = ~empty;
   assign out_float    = rdata[WIDTH-1:3];
   assign out_flags    = rdata[2:0];
   assign sticky_flags = sticky_q;
   assign exc_count    = exc_q;

endmodule

// File: tb/tb_float_div_result_queue.sv
// Self-checking bench: vector table plus scoreboard model of the queue.
module tb_float_div_result_queue;

   localparam int DEPTH = 4;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_float;
   logic        in_overflow, in_underflow, in_inexact;
   logic        out_valid, out_ready;
   logic [31:0] out_float;
   logic [2:0]  out_flags;
   logic [2:0]  count;
   logic [2:0]  sticky_flags;
   logic [7:0]  exc_count;
   logic        clear_status;

   float_div_result_queue #(.FLOAT_SIZE(32), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_float     (in_float),
      .in_overflow  (in_overflow),
      .in_underflow (in_underflow),
      .in_inexact   (in_inexact),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_float    (out_float),
      .out_flags    (out_flags),
      .count        (count),
      .sticky_flags (sticky_flags),
      .exc_count    (exc_count),
      .clear_status (clear_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests, fails;

   typedef struct packed {
      logic [31:0] f;
      logic [2:0]  fl;
   } entry_t;

   entry_t     sb[$];
   logic [2:0] m_sticky;
   int         m_exc;

   typedef struct {
      logic        v;
      logic [31:0] f;
      logic [2:0]  fl;
      logic        r;
      logic        clr;
      int          e_count;
      logic        e_ready;
      logic [31:0] e_float;
      logic [2:0]  e_flags;
      logic [2:0]  e_sticky;
      int          e_exc;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare DUT against scoreboard, then apply one clock with given inputs.
   task automatic cycle(input logic v, input logic [31:0] f, input logic [2:0] fl,
                        input logic r, input logic clr);
      logic acc;
      logic [2:0] base;
      int bexc;
      in_valid = v; in_float = f;
      in_overflow = fl[2]; in_underflow = fl[1]; in_inexact = fl[0];
      out_ready = r; clear_status = clr;
      chk("sb_count", 64'(count), 64'(sb.size()));
      chk("sb_out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("sb_in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
      if (sb.size() != 0) begin
         chk("sb_out_float", 64'(out_float), 64'(sb[0].f));
         chk("sb_out_flags", 64'(out_flags), 64'(sb[0].fl));
      end
      chk("sb_sticky", 64'(sticky_flags), 64'(m_sticky));
      chk("sb_exc", 64'(exc_count), 64'(m_exc));
      acc  = v && (sb.size() < DEPTH);
      base = clr ? 3'b000 : m_sticky;
      bexc = clr ? 0 : m_exc;
      if (acc) begin
         base = base | fl;
         if (fl != 3'b000 && bexc < 255) bexc++;
      end
      m_sticky = base;
      m_exc    = bexc;
      if (r && sb.size() != 0) void'(sb.pop_front());
      if (acc) sb.push_back('{f: f, fl: fl});
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int i);
      cycle(vecs[i].v, vecs[i].f, vecs[i].fl, vecs[i].r, vecs[i].clr);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_count));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ready));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_count != 0));
      if (vecs[i].e_count != 0) begin
         chk($sformatf("vec%0d_out_float", i), 64'(out_float), 64'(vecs[i].e_float));
         chk($sformatf("vec%0d_out_flags", i), 64'(out_flags), 64'(vecs[i].e_flags));
      end
      chk($sformatf("vec%0d_sticky", i), 64'(sticky_flags), 64'(vecs[i].e_sticky));
      chk($sformatf("vec%0d_exc", i), 64'(exc_count), 64'(vecs[i].e_exc));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      chk({tag, "_count"}, 64'(count), 64'(0));
      chk({tag, "_out_float"}, 64'(out_float), 64'(0));
      chk({tag, "_out_flags"}, 64'(out_flags), 64'(0));
      chk({tag, "_sticky"}, 64'(sticky_flags), 64'(0));
      chk({tag, "_exc"}, 64'(exc_count), 64'(0));
   endtask

   initial begin
      tests = 0; fails = 0;
      m_sticky = 3'b000; m_exc = 0;
      //         v  float         fl      r  clr cnt rdy head          hfl     stk     exc
      vecs[0]  = '{1, 32'h3F000000, 3'b000, 0, 0, 1, 1, 32'h3F000000, 3'b000, 3'b000, 0};
      vecs[1]  = '{0, 32'h00000000, 3'b000, 1, 0, 0, 1, 32'h00000000, 3'b000, 3'b000, 0};
      vecs[2]  = '{1, 32'h3F800000, 3'b000, 0, 0, 1, 1, 32'h3F800000, 3'b000, 3'b000, 0};
      vecs[3]  = '{1, 32'h40000000, 3'b000, 0, 0, 2, 1, 32'h3F800000, 3'b000, 3'b000, 0};
      vecs[4]  = '{1, 32'h40400000, 3'b000, 0, 0, 3, 1, 32'h3F800000, 3'b000, 3'b000, 0};
      vecs[5]  = '{1, 32'h40800000, 3'b000, 0, 0, 4, 0, 32'h3F800000, 3'b000, 3'b000, 0};
      vecs[6]  = '{1, 32'h40A00000, 3'b000, 0, 0, 4, 0, 32'h3F800000, 3'b000, 3'b000, 0};
      vecs[7]  = '{1, 32'h40A00000, 3'b000, 1, 0, 3, 1, 32'h40000000, 3'b000, 3'b000, 0};
      vecs[8]  = '{0, 32'h00000000, 3'b000, 1, 0, 2, 1, 32'h40400000, 3'b000, 3'b000, 0};
      vecs[9]  = '{1, 32'h3F800000, 3'b101, 1, 0, 1, 1, 32'h3F800000, 3'b101, 3'b101, 1};
      vecs[10] = '{1, 32'h40000000, 3'b010, 1, 0, 1, 1, 32'h40000000, 3'b010, 3'b111, 2};
      vecs[11] = '{1, 32'h40400000, 3'b001, 1, 1, 1, 1, 32'h40400000, 3'b001, 3'b001, 1};
      vecs[12] = '{0, 32'h00000000, 3'b000, 1, 0, 0, 1, 32'h00000000, 3'b000, 3'b001, 1};

      rst_n = 1'b0;
      in_valid = 0; in_float = '0; in_overflow = 0; in_underflow = 0; in_inexact = 0;
      out_ready = 0; clear_status = 0;
      #12;
      chk_reset("init");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i <= 8; i++) run_vec(i);

      // Steady push+pop at occupancy 2: pointers wrap several times.
      for (int i = 0; i < 10; i++) cycle(1'b1, 32'h41000000 + 32'(i), 3'b000, 1'b1, 1'b0);
      chk("wrap_count", 64'(count), 64'(2));
      chk("wrap_head", 64'(out_float), 64'(32'h41000008));
      cycle(1'b0, '0, 3'b000, 1'b1, 1'b0);
      cycle(1'b0, '0, 3'b000, 1'b1, 1'b0);

      for (int i = 9; i <= 12; i++) run_vec(i);

      // Clear alone wipes status without touching the empty queue.
      cycle(1'b0, '0, 3'b000, 1'b1, 1'b1);
      chk("clear_sticky", 64'(sticky_flags), 64'(0));
      chk("clear_exc", 64'(exc_count), 64'(0));

      // Saturation of the exception counter.
      for (int i = 0; i < 300; i++) cycle(1'b1, 32'h3F800000 + 32'(i), 3'b001, 1'b1, 1'b0);
      chk("sat_exc", 64'(exc_count), 64'(255));
      chk("sat_sticky", 64'(sticky_flags), 64'(3'b001));

      // Asynchronous reset in the middle of a push.
      in_valid = 1; in_float = 32'h12345678; in_overflow = 1; in_underflow = 0; in_inexact = 1;
      #2 rst_n = 1'b0;
      #1 chk_reset("async");
      sb.delete(); m_sticky = 3'b000; m_exc = 0;
      @(posedge clk);
      #1;
      in_valid = 0;
      rst_n = 1'b1;
      chk_reset("held");
      cycle(1'b1, 32'h3F000000, 3'b100, 1'b0, 1'b0);
      cycle(1'b0, '0, 3'b000, 1'b1, 1'b0);
      cycle(1'b0, '0, 3'b000, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
